ram_arbiter: RTL



---
 rtl/ram_arbiter.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: N-master front end sharing one single-port ram.
// One transaction in flight; adds timeout, bad-request reject and txs drain.
module ram_arbiter #(
   parameter int N       = 2,
   parameter int DW      = 32,
   parameter int AW      = 64,
   parameter int MODE    = 0,
   parameter int TIMEOUT = 1024
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    m_txe,
   input  logic [N-1:0]    m_re,
   input  logic [N-1:0]    m_we,
   input  logic [N*AW-1:0] m_addr,
   input  logic [N*DW-1:0] m_wd,
   output logic [N-1:0]    m_txs,
   output logic [N-1:0]    m_err,
   output logic [DW-1:0]   m_out,
   output logic            s_txe,
   output logic            s_re,
   output logic            s_we,
   output logic [AW-1:0]   s_addr,
   output logic [DW-1:0]   s_wd,
   input  logic            s_txs,
   input  logic [DW-1:0]   s_out,
   input  logic            s_err
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int TL = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [CW-1:0] CNT_LAST = CW'(TL);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [PW-1:0]   g_q, g_d;
   logic [PW-1:0]   gnt_idx;
   logic            gnt_vld;
   logic [N-1:0]    gnt_oh, g_oh;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            sel_re, sel_we;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_wd;
   logic            bad_req, to_hit;
   logic            s_txe_q, s_txe_d;
   logic            s_re_q, s_re_d;
   logic            s_we_q, s_we_d;
   logic [AW-1:0]   s_addr_q, s_addr_d;
   logic [DW-1:0]   s_wd_q, s_wd_d;
   logic [N-1:0]    m_txs_q, m_txs_d;
   logic [N-1:0]    m_err_q, m_err_d;
   logic [DW-1:0]   m_out_q, m_out_d;

   // Winner: smallest rotated distance from ptr (or from 0 when fixed priority)
   always_comb begin
      int best;
      int d;
      best    = N;
      d       = 0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < N; i++) begin
         d = (MODE == 0) ? i - int'(ptr_q) : i;
         if (d < 0) d = d + N;
         if (m_txe[i] && d < best) begin
            best    = d;
            gnt_vld = 1'b1;
            gnt_idx = PW'(i);
         end
      end
   end

   // Mux out the winner's request fields and build one-hot grant vectors
   always_comb begin
      sel_re   = 1'b0;
      sel_we   = 1'b0;
      sel_addr = '0;
      sel_wd   = '0;
      gnt_oh   = '0;
      g_oh     = '0;
      for (int i = 0; i < N; i++) begin
         if (gnt_idx == PW'(i)) begin
            sel_re    = m_re[i];
            sel_we    = m_we[i];
            sel_addr  = m_addr[i*AW +: AW];
            sel_wd    = m_wd[i*DW +: DW];
            gnt_oh[i] = gnt_vld;
         end
         g_oh[i] = (g_q == PW'(i));
      end
   end

   assign bad_req = (sel_re == sel_we);
   assign to_hit  = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   // State register plus all datapath registers; reset parks in RELEASE
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RELEASE;
         ptr_q    <= '0;
         g_q      <= '0;
         cnt_q    <= '0;
         s_txe_q  <= 1'b0;
         s_re_q   <= 1'b0;
         s_we_q   <= 1'b0;
         s_addr_q <= '0;
         s_wd_q   <= '0;
         m_txs_q  <= '0;
         m_err_q  <= '0;
         m_out_q  <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         g_q      <= g_d;
         cnt_q    <= cnt_d;
         s_txe_q  <= s_txe_d;
         s_re_q   <= s_re_d;
         s_we_q   <= s_we_d;
         s_addr_q <= s_addr_d;
         s_wd_q   <= s_wd_d;
         m_txs_q  <= m_txs_d;
         m_err_q  <= m_err_d;
         m_out_q  <= m_out_d;
      end
   end

   // Next state: RELEASE drains a level-held s_txs before re-arbitrating
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (gnt_vld) state_d = bad_req ? RELEASE : BUSY;
         end
         BUSY: begin
            if (s_txs || to_hit) state_d = RELEASE;
         end
         RELEASE: begin
            if (!s_txs) state_d = IDLE;
         end
         default: state_d = RELEASE;
      endcase
   end

   // Outputs: grant latch, slave strobes, completion pulse and timeout count
   always_comb begin
      ptr_d    = ptr_q;
      g_d      = g_q;
      cnt_d    = cnt_q;
      s_txe_d  = 1'b0;
      s_re_d   = 1'b0;
      s_we_d   = 1'b0;
      s_addr_d = s_addr_q;
      s_wd_d   = s_wd_q;
      m_txs_d  = '0;
      m_err_d  = '0;
      m_out_d  = '0;
      unique case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               g_d   = gnt_idx;
               ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
               if (bad_req) begin
                  m_txs_d = gnt_oh;
                  m_err_d = gnt_oh;
               end else begin
                  s_txe_d  = 1'b1;
                  s_re_d   = sel_re;
                  s_we_d   = sel_we;
                  s_addr_d = sel_addr;
                  s_wd_d   = sel_wd;
                  cnt_d    = '0;
               end
            end
         end
         BUSY: begin
            if (s_txs) begin
               m_txs_d = g_oh;
               m_err_d = s_err ? g_oh : '0;
               m_out_d = s_out;
            end else if (to_hit) begin
               m_txs_d = g_oh;
               m_err_d = g_oh;
            end else begin
               s_txe_d = s_txe_q;
               s_re_d  = s_re_q;
               s_we_d  = s_we_q;
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign m_txs  = m_txs_q;
   assign m_err  = m_err_q;
   assign m_out  = m_out_q;
   assign s_txe  = s_txe_q;
   assign s_re   = s_re_q;
   assign s_we   = s_we_q;
   assign s_addr = s_addr_q;
   assign s_wd   = s_wd_q;

endmodule
